// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and the round-robin step helper for the memory port arbiter
package mem_arb_pkg;
  localparam int NUM_REQ = 3;
  typedef enum logic {IDLE, BUSY} arb_state_t;
  typedef logic [1:0] req_idx_t;
  function automatic req_idx_t rr_next(input req_idx_t i);
    return i == 2'd2 ? 2'd0 : i + 2'd1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin pick among three requesters starting at ptr
//   req [2:0] in  : request vector, bit k = requester k
//   ptr [1:0] in  : highest-priority requester index (0..2)
//   vld       out : any request present
//   win [1:0] out : winning requester index, meaningful only when vld
module rr_pick
  import mem_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  req_idx_t           ptr,
  output logic               vld,
  output req_idx_t           win
);
  logic [3:0] r;
  req_idx_t c1;
  req_idx_t c2;
  assign r = {1'b0, req};
  assign c1 = rr_next(ptr);
  assign c2 = rr_next(c1);
  assign vld = |req;
  assign win = r[ptr] ? ptr : r[c1] ? c1 : c2;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin grant and watchdog sequencer for the shared 64-bit memory port
//   i_clk, i_arst         : clock, async active-low reset
//   i_req [2:0]           : level requests (0 icache refill, 1 dcache refill, 2 dcache write-back)
//   i_done                : one-cycle completion pulse from the port
//   i_timeout_clr         : clears the sticky timeout flag
//   o_grant [2:0]         : one-hot grant, zero when idle
//   o_mux_sel [1:0]       : encoded mux select, holds last grant while idle
//   o_start, o_busy       : first-cycle pulse and active-grant level
//   o_timeout             : sticky watchdog-release flag
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int unsigned MAX_HOLD  = 1024,
  localparam int unsigned CNT_WIDTH = $clog2(MAX_HOLD + 1)
) (
  input  logic               i_clk,
  input  logic               i_arst,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_done,
  input  logic               i_timeout_clr,
  output logic [NUM_REQ-1:0] o_grant,
  output req_idx_t           o_mux_sel,
  output logic               o_start,
  output logic               o_busy,
  output logic               o_timeout
);
  arb_state_t state;
  req_idx_t ptr;
  req_idx_t win;
  logic vld;
  logic [CNT_WIDTH-1:0] cnt;
  rr_pick u_pick (.req(i_req), .ptr(ptr), .vld(vld), .win(win));
  assign o_busy = state == BUSY;
  assign o_grant = o_busy ? NUM_REQ'(1) << o_mux_sel : '0;
  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      o_mux_sel <= '0;
      o_start   <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      o_start <= 1'b0;
      if (i_timeout_clr) o_timeout <= 1'b0;
      if (state == IDLE) begin
        if (vld) begin
          state     <= BUSY;
          o_mux_sel <= win;
          ptr       <= rr_next(win);
          cnt       <= '0;
          o_start   <= 1'b1;
        end
      end else if (i_done) begin
        state <= IDLE;
      end else if (cnt == CNT_WIDTH'(MAX_HOLD - 1)) begin
        // watchdog release; ordered after the clear so a same-cycle set wins
        state     <= IDLE;
        o_timeout <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule
